fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the max WAIT/DRAIN cycles before fetch_err (range 1..255).
REQ-002 SHALL have port clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  in  1  fetch enable.
REQ-005 SHALL have port pc  in  16  current program-counter value.
REQ-006 SHALL have ports inc_pc, pc_load  out  1  PC increment / load strobes.
REQ-007 SHALL have port pc_data  out  16  PC load value.
REQ-008 SHALL have ports mem_rd  out  1 and mem_addr  out  16  read request and address.
REQ-009 SHALL have ports mem_valid  in  1 and mem_rdata  in  16  read return.
REQ-010 SHALL have ports ir  out  16, ir_valid  out  1 and ir_ack  in  1  instruction handoff.
REQ-011 SHALL have ports branch_req  in  1 and branch_target  in  16  redirect request.
REQ-012 SHALL have port fetch_err  out  1  sticky memory-timeout flag.

Function
REQ-013 SHALL register all outputs; no combinational input-to-output path.
REQ-014 SHALL implement states IDLE, REQ, WAIT, FULL, BR, DRAIN.
REQ-015 IDLE: run=1 -> REQ; else stay.
REQ-016 REQ: mem_rd=1, mem_addr=pc for exactly one cycle; set outstanding; -> WAIT.
REQ-017 WAIT: mem_valid=1 -> ir<=mem_rdata, ir_valid<=1, inc_pc pulsed one cycle, clear outstanding, -> FULL.
REQ-018 FULL: ir and ir_valid held stable until ir_ack; ir_valid drops the cycle after ack; -> REQ if run else IDLE.
REQ-019 run deasserted in REQ/WAIT SHALL NOT abort the fetch; it completes through FULL, then IDLE.
REQ-020 branch_req sampled in IDLE/REQ/WAIT/FULL -> BR: pc_load=1, pc_data=branch_target for exactly one cycle; ir_valid cleared.
REQ-021 BR exit: -> DRAIN if outstanding, else REQ (new pc visible to REQ).
REQ-022 DRAIN: discard mem_valid data, no inc_pc, clear outstanding, -> REQ.
REQ-023 branch_req and mem_valid in the same WAIT cycle: branch wins, data discarded, no inc_pc, outstanding cleared.
REQ-024 branch_req during BR or DRAIN: retarget pc_data, re-enter BR.
REQ-025 inc_pc and pc_load SHALL never assert together; each SHALL be a single-cycle pulse.
REQ-026 At most one outstanding read; mem_rd SHALL NOT assert while outstanding=1.
REQ-027 pc=16'hFFFF SHALL be fetched normally; wrap is the counter's concern.

Reset
REQ-028 reset SHALL force IDLE and clear outstanding and the timeout counter.
REQ-029 reset SHALL clear ir, pc_data and mem_addr to 16'h0000.
REQ-030 reset SHALL clear inc_pc, pc_load, mem_rd, ir_valid and fetch_err to 0.
REQ-031 A reply arriving after mid-fetch reset SHALL be ignored (outstanding=0, state IDLE).

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined: an 8-bit counter runs in WAIT/DRAIN.
REQ-033 With FETCH_TIMEOUT_EN defined: reaching TIMEOUT_CYCLES sets fetch_err (sticky until reset), clears outstanding, and forces IDLE.
REQ-034 Without FETCH_TIMEOUT_EN: fetch_err tied 0, no counter, WAIT/DRAIN wait indefinitely.

Structure
REQ-035 A shared package SHALL hold the state enumeration encoding and the 16-bit word-width constant.
REQ-036 A sub-module fetch_timeout SHALL hold the timeout counter, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-037 Bench: reset, run=1, pc=16'h0010, mem_valid 2 cycles after mem_rd, rdata 16'hA5A5 -> mem_addr=16'h0010, ir=16'hA5A5, ir_valid=1, one inc_pc pulse.
REQ-038 Bench: ir_ack held 0 for 5 cycles -> ir stable, no mem_rd; ack -> next mem_rd 1 cycle after ir_valid falls.
REQ-039 Bench: branch_req with target 16'h0200 in WAIT, late reply 16'hDEAD -> pc_load pulse, pc_data=16'h0200, DRAIN discards reply, next mem_addr=16'h0200, no inc_pc.
REQ-040 Bench: branch_req and mem_valid same cycle -> ir_valid stays 0, no inc_pc, pc_load=1.
REQ-041 Bench: reset asserted in WAIT, reply after release -> all outputs 0, reply ignored, IDLE.
REQ-042 Bench: with FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no mem_valid -> fetch_err=1 after 4 WAIT cycles, IDLE, sticky until reset.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: state encoding and word width shared by the fetch sequencer files.
package fetch_sequencer_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FULL  = 3'd3,
    BR    = 3'd4,
    DRAIN = 3'd5
  } state_t;

endpackage

// File: rtl/fetch_sequencer_timeout.sv
// fetch_timeout: counts consecutive cycles spent waiting on memory and flags
// the last allowed cycle. Only compiled when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic i_active,
  output logic o_expired
);

  logic [7:0] r_count;

  // Count while the sequencer waits; any other state restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (!i_active) begin
      r_count <= 8'd0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = i_active && (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM sitting between the PC, memory and decode.
// Optional feature: define FETCH_TIMEOUT_EN to abort a stalled read after
// TIMEOUT_CYCLES waiting cycles and raise the sticky fetch_err flag.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [WORD_W-1:0] pc,
  output logic              inc_pc,
  output logic              pc_load,
  output logic [WORD_W-1:0] pc_data,
  output logic              mem_rd,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ack,
  input  logic              branch_req,
  input  logic [WORD_W-1:0] branch_target,
  output logic              fetch_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
    $error("fetch_sequencer: TIMEOUT_CYCLES must lie in 1..255");
  end

  state_t            r_state, w_stateNext;
  logic              r_outstanding, w_outstandingNext;
  logic              r_incPc, w_incPcNext;
  logic              r_pcLoad, w_pcLoadNext;
  logic              r_memRd, w_memRdNext;
  logic              r_irValid, w_irValidNext;
  logic              r_fetchErr, w_fetchErrNext;
  logic [WORD_W-1:0] r_pcData, w_pcDataNext;
  logic [WORD_W-1:0] r_memAddr, w_memAddrNext;
  logic [WORD_W-1:0] r_ir, w_irNext;
  logic              w_takeBranch;
  logic              w_timeout;

`ifdef FETCH_TIMEOUT_EN
  logic w_timeoutActive;
  assign w_timeoutActive = (r_state == WAIT) || (r_state == DRAIN);

  fetch_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_active  (w_timeoutActive),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // State and every output live in flops so no input reaches an output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_outstanding <= 1'b0;
      r_incPc       <= 1'b0;
      r_pcLoad      <= 1'b0;
      r_memRd       <= 1'b0;
      r_irValid     <= 1'b0;
      r_fetchErr    <= 1'b0;
      r_pcData      <= '0;
      r_memAddr     <= '0;
      r_ir          <= '0;
    end else begin
      r_state       <= w_stateNext;
      r_outstanding <= w_outstandingNext;
      r_incPc       <= w_incPcNext;
      r_pcLoad      <= w_pcLoadNext;
      r_memRd       <= w_memRdNext;
      r_irValid     <= w_irValidNext;
      r_fetchErr    <= w_fetchErrNext;
      r_pcData      <= w_pcDataNext;
      r_memAddr     <= w_memAddrNext;
      r_ir          <= w_irNext;
    end
  end

  // Next state and next output values; a branch request overrides whatever the state wanted.
  always_comb begin
    w_stateNext       = r_state;
    w_outstandingNext = r_outstanding;
    w_incPcNext       = 1'b0;
    w_pcLoadNext      = 1'b0;
    w_memRdNext       = 1'b0;
    w_irValidNext     = r_irValid;
    w_fetchErrNext    = r_fetchErr;
    w_pcDataNext      = r_pcData;
    w_memAddrNext     = r_memAddr;
    w_irNext          = r_ir;
    w_takeBranch      = 1'b0;

    case (r_state)
      IDLE: begin
        if (branch_req) begin
          w_takeBranch = 1'b1;
        end else if (run) begin
          w_stateNext = REQ;
        end
      end
      REQ: begin
        if (branch_req) begin
          w_takeBranch = 1'b1;
        end else begin
          w_memRdNext       = 1'b1;
          w_memAddrNext     = pc;
          w_outstandingNext = 1'b1;
          w_stateNext       = WAIT;
        end
      end
      WAIT: begin
        if (branch_req) begin
          w_takeBranch = 1'b1;
          if (mem_valid) begin
            w_outstandingNext = 1'b0;
          end
        end else if (mem_valid) begin
          w_irNext          = mem_rdata;
          w_irValidNext     = 1'b1;
          w_incPcNext       = 1'b1;
          w_outstandingNext = 1'b0;
          w_stateNext       = FULL;
        end else if (w_timeout) begin
          w_fetchErrNext    = 1'b1;
          w_outstandingNext = 1'b0;
          w_stateNext       = IDLE;
        end
      end
      FULL: begin
        if (branch_req) begin
          w_takeBranch = 1'b1;
        end else if (ir_ack) begin
          w_irValidNext = 1'b0;
          w_stateNext   = run ? REQ : IDLE;
        end
      end
      BR: begin
        if (mem_valid) begin
          w_outstandingNext = 1'b0;
        end
        if (branch_req) begin
          w_takeBranch = 1'b1;
        end else if (w_outstandingNext) begin
          w_stateNext = DRAIN;
        end else begin
          w_stateNext = REQ;
        end
      end
      DRAIN: begin
        if (mem_valid) begin
          w_outstandingNext = 1'b0;
        end
        if (branch_req) begin
          w_takeBranch = 1'b1;
        end else if (mem_valid) begin
          w_stateNext = REQ;
        end else if (w_timeout) begin
          w_fetchErrNext    = 1'b1;
          w_outstandingNext = 1'b0;
          w_stateNext       = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    if (w_takeBranch) begin
      w_stateNext   = BR;
      w_pcLoadNext  = 1'b1;
      w_pcDataNext  = branch_target;
      w_irValidNext = 1'b0;
    end
  end

  assign inc_pc    = r_incPc;
  assign pc_load   = r_pcLoad;
  assign pc_data   = r_pcData;
  assign mem_rd    = r_memRd;
  assign mem_addr  = r_memAddr;
  assign ir        = r_ir;
  assign ir_valid  = r_irValid;
  assign fetch_err = r_fetchErr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios followed by a randomized run in which
// a memory with random latency, a PC register and a decoder drive the DUT, and
// an address/instruction scoreboard predicts what must be fetched and handed off.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        run;
  logic [15:0] pc;
  logic        inc_pc;
  logic        pc_load;
  logic [15:0] pc_data;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ack;
  logic        branch_req;
  logic [15:0] branch_target;
  logic        fetch_err;

  logic        pcPresetEn;
  logic [15:0] pcPresetVal;

  int testCount = 0;
  int failCount = 0;

  logic [15:0] expAddr;
  logic [15:0] replyAddr;
  bit          pending;
  int          countdown;
  int          cooldown;
  int          incCount;
  int          delivered;
  int          quiet;
  bit          prevInc;
  bit          prevLoad;

`ifdef FETCH_TIMEOUT_EN
  localparam logic ERR_EXPECT = 1'b1;
`else
  localparam logic ERR_EXPECT = 1'b0;
`endif

  fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .pc            (pc),
    .inc_pc        (inc_pc),
    .pc_load       (pc_load),
    .pc_data       (pc_data),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_valid     (mem_valid),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ir_ack        (ir_ack),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .fetch_err     (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program counter that obeys the DUT's load/increment strobes.
  always @(posedge clock) begin
    if (pcPresetEn) begin
      pc <= pcPresetVal;
    end else if (pc_load) begin
      pc <= pc_data;
    end else if (inc_pc) begin
      pc <= pc + 16'd1;
    end
  end

  // Memory contents: a distinct word for every address.
  function automatic logic [15:0] memWord(input logic [15:0] addr);
    return {addr[7:0], addr[15:8]} ^ 16'h5AC3;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One cycle of the random environment: check, serve memory, ack/branch, pick run.
  task automatic applyStimulus(input bit randomPhase);
    @(negedge clock);
    checkOutput("incWithLoad", 16'(inc_pc & pc_load), 16'h0);
    checkOutput("incPulse", 16'(inc_pc & prevInc), 16'h0);
    checkOutput("loadPulse", 16'(pc_load & prevLoad), 16'h0);
    checkOutput("noErr", 16'(fetch_err), 16'h0);
    prevInc  = inc_pc;
    prevLoad = pc_load;
    if (inc_pc) incCount++;
    if (mem_rd) begin
      checkOutput("rdWhilePending", 16'(pending), 16'h0);
      checkOutput("rdAddr", mem_addr, expAddr);
      checkOutput("rdAddrPc", mem_addr, pc);
      pending   = 1'b1;
      replyAddr = mem_addr;
      countdown = $urandom_range(3, 0);
    end
    if (pending && countdown == 0) begin
      mem_valid = 1'b1;
      mem_rdata = memWord(replyAddr);
      pending   = 1'b0;
    end else begin
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
      if (pending) countdown--;
    end
    ir_ack     = 1'b0;
    branch_req = 1'b0;
    if (ir_valid && (!randomPhase || $urandom_range(2, 0) == 0)) begin
      ir_ack = 1'b1;
      checkOutput("irData", ir, memWord(expAddr));
      expAddr = expAddr + 16'd1;
      delivered++;
    end else if (randomPhase && !ir_valid && cooldown == 0 && $urandom_range(7, 0) == 0) begin
      branch_req    = 1'b1;
      branch_target = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
      expAddr       = branch_target;
      cooldown      = 6;
    end
    if (cooldown > 0) cooldown--;
    run = randomPhase ? ($urandom_range(7, 0) != 0) : 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_valid = 1'b0; mem_rdata = 16'h0;
    ir_ack = 1'b0; branch_req = 1'b0; branch_target = 16'h0;
    pcPresetEn = 1'b1; pcPresetVal = 16'h0010;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rstMemRd", 16'(mem_rd), 16'h0);
    checkOutput("rstMemAddr", mem_addr, 16'h0);
    checkOutput("rstIr", ir, 16'h0);
    checkOutput("rstIrValid", 16'(ir_valid), 16'h0);
    checkOutput("rstPcData", pc_data, 16'h0);
    checkOutput("rstIncPc", 16'(inc_pc), 16'h0);
    checkOutput("rstPcLoad", 16'(pc_load), 16'h0);
    checkOutput("rstErr", 16'(fetch_err), 16'h0);

    // Basic fetch from 0x0010 with the reply two cycles after the read.
    reset = 1'b0; pcPresetEn = 1'b0; run = 1'b1;
    @(negedge clock);
    checkOutput("reqNoRdYet", 16'(mem_rd), 16'h0);
    @(negedge clock);
    checkOutput("fetchRd", 16'(mem_rd), 16'h1);
    checkOutput("fetchAddr", mem_addr, 16'h0010);
    @(negedge clock);
    checkOutput("rdOnePulse", 16'(mem_rd), 16'h0);
    @(negedge clock);
    mem_valid = 1'b1; mem_rdata = 16'hA5A5;
    @(negedge clock);
    mem_valid = 1'b0;
    checkOutput("fetchIr", ir, 16'hA5A5);
    checkOutput("fetchIrValid", 16'(ir_valid), 16'h1);
    checkOutput("fetchIncPc", 16'(inc_pc), 16'h1);

    // Decoder stalls: instruction must hold and no new read may start.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("stallIr", ir, 16'hA5A5);
      checkOutput("stallIrValid", 16'(ir_valid), 16'h1);
      checkOutput("stallNoRd", 16'(mem_rd), 16'h0);
      checkOutput("stallNoInc", 16'(inc_pc), 16'h0);
    end
    ir_ack = 1'b1;
    @(negedge clock);
    ir_ack = 1'b0;
    checkOutput("ackDrop", 16'(ir_valid), 16'h0);
    checkOutput("ackNoRdYet", 16'(mem_rd), 16'h0);
    @(negedge clock);
    checkOutput("nextRd", 16'(mem_rd), 16'h1);
    checkOutput("nextAddr", mem_addr, 16'h0011);

    // Branch while waiting; the late reply must be drained.
    branch_req = 1'b1; branch_target = 16'h0200;
    @(negedge clock);
    branch_req = 1'b0;
    checkOutput("brLoad", 16'(pc_load), 16'h1);
    checkOutput("brData", pc_data, 16'h0200);
    checkOutput("brNoInc", 16'(inc_pc), 16'h0);
    @(negedge clock);
    checkOutput("brLoadPulse", 16'(pc_load), 16'h0);
    checkOutput("drainNoRd", 16'(mem_rd), 16'h0);
    mem_valid = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clock);
    mem_valid = 1'b0;
    checkOutput("drainIrValid", 16'(ir_valid), 16'h0);
    checkOutput("drainNoInc", 16'(inc_pc), 16'h0);
    @(negedge clock);
    checkOutput("brRd", 16'(mem_rd), 16'h1);
    checkOutput("brAddr", mem_addr, 16'h0200);
    checkOutput("drainIrKept", ir, 16'hA5A5);

    // Branch and reply in the same cycle: branch wins.
    mem_valid = 1'b1; mem_rdata = 16'h1234;
    branch_req = 1'b1; branch_target = 16'h0300;
    @(negedge clock);
    mem_valid = 1'b0; branch_req = 1'b0;
    checkOutput("tieIrValid", 16'(ir_valid), 16'h0);
    checkOutput("tieNoInc", 16'(inc_pc), 16'h0);
    checkOutput("tieLoad", 16'(pc_load), 16'h1);
    checkOutput("tieIr", ir, 16'hA5A5);
    @(negedge clock);
    checkOutput("tieNoDrainRd", 16'(mem_rd), 16'h0);
    @(negedge clock);
    checkOutput("tieRd", 16'(mem_rd), 16'h1);
    checkOutput("tieAddr", mem_addr, 16'h0300);

    // Reset in the middle of a fetch; the reply afterwards is ignored.
    reset = 1'b1; run = 1'b0;
    @(negedge clock);
    checkOutput("midRstMemRd", 16'(mem_rd), 16'h0);
    checkOutput("midRstMemAddr", mem_addr, 16'h0);
    checkOutput("midRstIr", ir, 16'h0);
    checkOutput("midRstIrValid", 16'(ir_valid), 16'h0);
    checkOutput("midRstPcData", pc_data, 16'h0);
    checkOutput("midRstPcLoad", 16'(pc_load), 16'h0);
    reset = 1'b0;
    @(negedge clock);
    mem_valid = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clock);
    mem_valid = 1'b0;
    checkOutput("staleIrValid", 16'(ir_valid), 16'h0);
    checkOutput("staleIr", ir, 16'h0);
    checkOutput("staleIncPc", 16'(inc_pc), 16'h0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("staleIdleRd", 16'(mem_rd), 16'h0);
    checkOutput("staleIdleIrValid", 16'(ir_valid), 16'h0);

    // Memory never answers: timeout after four waiting cycles when enabled.
    run = 1'b1;
    @(negedge clock);
    @(negedge clock);
    run = 1'b0;
    checkOutput("toRd", 16'(mem_rd), 16'h1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("toErrEarly", 16'(fetch_err), 16'h0);
      @(negedge clock);
    end
    checkOutput("toErr", 16'(fetch_err), 16'(ERR_EXPECT));
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
    end
    checkOutput("toErrSticky", 16'(fetch_err), 16'(ERR_EXPECT));
    checkOutput("toIdleRd", 16'(mem_rd), 16'h0);
    reset = 1'b1; pcPresetEn = 1'b1; pcPresetVal = 16'hFFFC;
    @(negedge clock);
    checkOutput("toErrCleared", 16'(fetch_err), 16'h0);
    @(negedge clock);
    reset = 1'b0; pcPresetEn = 1'b0;

    // Randomized traffic starting just below the address wrap.
    expAddr = 16'hFFFC; pending = 1'b0; countdown = 0; cooldown = 0;
    incCount = 0; delivered = 0; prevInc = 1'b0; prevLoad = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(1'b1);
    end
    quiet = 0;
    for (int c = 0; c < 200 && quiet < 6; c++) begin
      applyStimulus(1'b0);
      quiet = (!ir_valid && !pending && !mem_rd) ? quiet + 1 : 0;
    end
    checkOutput("drainedIdle", 16'(quiet >= 6), 16'h1);
    checkOutput("incCount", 16'(incCount), 16'(delivered));
    checkOutput("deliveredSome", 16'(delivered > 20), 16'h1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
